seg7_scan_driver: RTL and testbench

//  Consumer end of the 32-bit display / 8-bit displayEnable bus produced by the sequence automaton.

---
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Eight-digit multiplexed hex driver for a 7-segment bank. Inputs are snapshotted once
// per scan frame, and a short all-off gap at each digit switch suppresses ghosting.
module seg7_scan_driver #(
    parameter int TICK_DIV   = 100000,
    parameter int BLANK_CYC  = 16,
    parameter int ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] display,
    input  logic [7:0]  displayEnable,
    input  logic [7:0]  dp_in,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_done
);

    localparam int             CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  DIV_MAX   = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0]  BLANK_LIM = CW'(BLANK_CYC);
    localparam logic [7:0]     POL8      = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [6:0]     POL7      = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic           POL1      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [CW-1:0] div_cnt_r;
    logic [2:0]    idx_r;
    logic [31:0]   shadow_data_r;
    logic [7:0]    shadow_en_r;
    logic [7:0]    shadow_dp_r;
    logic          frame_done_r;
    logic [7:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;

    logic          tick_s;
    logic          wrap_s;
    phase_t        phase_s;
    logic [3:0]    digit_s;
    logic [7:0]    an_next_s;

    // Slot timing decode: the slot phase is implied directly by the prescaler count.
    always_comb begin
        tick_s  = (div_cnt_r == DIV_MAX);
        wrap_s  = tick_s && (idx_r == 3'd7);
        digit_s = shadow_data_r[{idx_r, 2'b00} +: 4];
        if (div_cnt_r < BLANK_LIM) begin
            phase_s = PH_BLANK;
        end else begin
            phase_s = PH_SHOW;
        end
    end

    // Anode for the current slot in active-high form, before polarity is applied.
    always_comb begin
        an_next_s = 8'h00;
        if ((phase_s == PH_SHOW) && shadow_en_r[idx_r]) begin
            an_next_s = 8'h01 << idx_r;
        end else begin
            an_next_s = 8'h00;
        end
    end

    // Prescaler, digit index, frame pulse and once-per-frame input snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r     <= '0;
            idx_r         <= 3'd0;
            shadow_data_r <= 32'h0000_0000;
            shadow_en_r   <= 8'h00;
            shadow_dp_r   <= 8'h00;
            frame_done_r  <= 1'b0;
        end else begin
            frame_done_r <= wrap_s;
            if (tick_s) begin
                div_cnt_r <= '0;
                idx_r     <= idx_r + 3'd1;
            end else begin
                div_cnt_r <= div_cnt_r + CW'(1);
            end
            if (wrap_s) begin
                shadow_data_r <= display;
                shadow_en_r   <= displayEnable;
                shadow_dp_r   <= dp_in;
            end
        end
    end

    // Registered pin drive; XOR with the polarity mask makes 'inactive' the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_r  <= POL8;
            seg_r <= POL7;
            dp_r  <= POL1;
        end else begin
            an_r  <= an_next_s ^ POL8;
            seg_r <= hex_decode(digit_s) ^ POL7;
            dp_r  <= shadow_dp_r[idx_r] ^ POL1;
        end
    end

    assign AN         = an_r;
    assign SEG        = seg_r;
    assign DP         = dp_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-position reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_seg7_scan_driver;

    localparam int TD  = 4;
    localparam int BC  = 1;
    localparam int FRM = 8 * TD;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] display;
    logic [7:0]  displayEnable;
    logic [7:0]  dp_in;
    logic [7:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(.TICK_DIV(TD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .display(display), .displayEnable(displayEnable),
        .dp_in(dp_in), .AN(AN), .SEG(SEG), .DP(DP), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position p within the frame since reset, shadow copy of inputs.
    logic [6:0]  hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    int          p = 0;
    logic [31:0] m_data = 32'h0;
    logic [7:0]  m_en   = 8'h0;
    logic [7:0]  m_dp   = 8'h0;
    logic [7:0]  e_an   = 8'hFF;
    logic [6:0]  e_seg  = 7'h7F;
    logic        e_dp   = 1'b1;
    logic        e_fd   = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                p = 0; m_data = 32'h0; m_en = 8'h0; m_dp = 8'h0;
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
            end else begin
                int slot;
                int off;
                slot  = p / TD;
                off   = p % TD;
                e_an  = 8'hFF;
                if (off >= BC && m_en[slot]) e_an[slot] = 1'b0;
                e_seg = ~hex_tab[m_data[slot*4 +: 4]];
                e_dp  = ~m_dp[slot];
                e_fd  = (p == FRM - 1);
                if (p == FRM - 1) begin
                    m_data = display; m_en = displayEnable; m_dp = dp_in;
                end
                p = (p + 1) % FRM;
            end
            @(negedge clk);
            check("an",         AN,                 e_an);
            check("seg",        {1'b0, SEG},        {1'b0, e_seg});
            check("dp",         {7'b0, DP},         {7'b0, e_dp});
            check("frame_done", {7'b0, frame_done}, {7'b0, e_fd});
        end
    end

    initial begin
        int cnt_ff, cnt_fe, cnt_other, cnt_a, cnt_b, last_fd, gap_bad;
        logic [6:0] seg_fe, seg_7f;

        // 1. reset
        rst = 1'b1; display = 32'h0; displayEnable = 8'h00; dp_in = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_an",  AN, 8'hFF);
        check("reset_seg", {1'b0, SEG}, 8'h7F);
        check("reset_dp",  {7'b0, DP}, 8'h01);
        check("reset_fd",  {7'b0, frame_done}, 8'h00);
        rst = 1'b0;

        // 2. all digits, dark first frame then own values
        display = 32'h7654_3210; displayEnable = 8'hFF; dp_in = 8'h00;
        cnt_ff = 0; cnt_fe = 0; seg_fe = 7'h7F; seg_7f = 7'h7F;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            if (AN == 8'hFF) cnt_ff++;
            if (AN == 8'hFE) begin cnt_fe++; seg_fe = SEG; end
            if (AN == 8'h7F) seg_7f = SEG;
        end
        check("t2_ff_count", 8'(cnt_ff), 8'd40);
        check("t2_fe_count", 8'(cnt_fe), 8'd3);
        check("t2_seg_d0",   {1'b0, seg_fe}, 8'h40);
        check("t2_seg_d7",   {1'b0, seg_7f}, 8'h78);

        // 3. only digit 0 enabled, showing F
        display = 32'h7654_321F; displayEnable = 8'h01;
        cnt_fe = 0; cnt_other = 0; seg_fe = 7'h7F;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            if (i >= FRM) begin
                if (AN == 8'hFE) begin cnt_fe++; seg_fe = SEG; end
                else if (AN != 8'hFF) cnt_other++;
            end
        end
        check("t3_fe_count", 8'(cnt_fe), 8'd3);
        check("t3_other",    8'(cnt_other), 8'd0);
        check("t3_seg_F",    {1'b0, seg_fe}, 8'h0E);

        // 4. mid-frame change must not tear
        display = 32'h0; displayEnable = 8'hFF;
        repeat (FRM + FRM / 2) @(negedge clk);
        display = 32'h8888_8888;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < FRM + FRM / 2; i++) begin
            @(negedge clk);
            if (i < FRM / 2 && SEG == 7'h40) cnt_a++;
            if (i >= FRM / 2 && SEG == 7'h00) cnt_b++;
        end
        check("t4_old_frame", 8'(cnt_a), 8'd16);
        check("t4_new_frame", 8'(cnt_b), 8'd32);

        // 5. frame_done pulses over 5 frames
        cnt_a = 0; last_fd = -1; gap_bad = 0;
        for (int i = 0; i < 5 * FRM; i++) begin
            @(negedge clk);
            if (frame_done) begin
                if (last_fd >= 0 && i - last_fd != FRM) gap_bad++;
                last_fd = i;
                cnt_a++;
            end
        end
        check("t5_pulses",  8'(cnt_a), 8'd5);
        check("t5_spacing", 8'(gap_bad), 8'd0);

        // 6. reset while idx=5; dp only visible a frame later
        dp_in = 8'hFF;
        repeat (21) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_an",  AN, 8'hFF);
        check("t6_seg", {1'b0, SEG}, 8'h7F);
        check("t6_dp",  {7'b0, DP}, 8'h01);
        rst = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_ff = 0;
        for (int i = 0; i < 2 * FRM; i++) begin
            @(negedge clk);
            if (i < FRM && !DP) cnt_a++;
            if (i < FRM && AN == 8'hFF) cnt_ff++;
            if (i >= FRM && !DP) cnt_b++;
        end
        check("t6_dark_dp",  8'(cnt_a), 8'd0);
        check("t6_dark_an",  8'(cnt_ff), 8'd32);
        check("t6_dp_later", 8'(cnt_b), 8'd32);

        // randomized run, occasionally including displayEnable=00 and resets
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) begin
                display = $urandom;
                displayEnable = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                dp_in = 8'($urandom);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
